// File: rtl/mux_pipe_n.sv
// N-input, W-bit lane selector with a single-entry registered output stage
// and valid/ready handshaking on both sides.
module mux_pipe_n #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  logic [WIDTH-1:0]  lane   [NUM_IN];
  logic [WIDTH-1:0]  masked [NUM_IN];
  logic [NUM_IN-1:0] hit;
  logic [WIDTH-1:0]  data_next;
  logic              in_range;
  logic              accept;
  logic              drain;

  logic [WIDTH-1:0]  data_reg;
  logic [SEL_W-1:0]  sel_reg;
  logic              valid_reg;
  logic              err_reg;

  // One-hot lane match; an out-of-range sel matches nothing and yields zero data.
  // This avoids a constant comparison when NUM_IN is a power of two.
  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lane
      assign lane[gi]   = in_data[gi*WIDTH +: WIDTH];
      assign hit[gi]    = (sel == SEL_W'(gi));
      assign masked[gi] = hit[gi] ? lane[gi] : '0;
    end
  endgenerate

  always_comb begin
    data_next = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      data_next = data_next | masked[k];
    end
  end

  assign in_range = |hit;
  assign in_ready = !valid_reg || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = valid_reg && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_reg  <= '0;
      sel_reg   <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        data_reg  <= data_next;
        sel_reg   <= sel;
        valid_reg <= 1'b1;
      end else if (drain) begin
        valid_reg <= 1'b0;
      end
      if (accept && !in_range) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign out_data  = data_reg;
  assign out_sel   = sel_reg;
  assign out_valid = valid_reg;
  assign sel_err   = err_reg;

endmodule

// File: tb/tb_mux_pipe_n.sv
// Directed checks on a 3-lane x 5-bit instance, then a randomized scoreboard
// run on a 4-lane x 32-bit instance.
module tb_mux_pipe_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: WIDTH=5, NUM_IN=3
  logic        rst_n;
  logic [14:0] in_data;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic        sel_err;

  mux_pipe_n #(.WIDTH(5), .NUM_IN(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err)
  );

  // Instance B: WIDTH=32, NUM_IN=4
  logic         rst_n2;
  logic [127:0] in_data2;
  logic [1:0]   sel2;
  logic         in_valid2;
  logic         in_ready2;
  logic [31:0]  out_data2;
  logic [1:0]   out_sel2;
  logic         out_valid2;
  logic         out_ready2;
  logic         sel_err2;

  mux_pipe_n #(.WIDTH(32), .NUM_IN(4)) dut_b (
    .clk(clk), .rst_n(rst_n2), .in_data(in_data2), .sel(sel2),
    .in_valid(in_valid2), .in_ready(in_ready2), .out_data(out_data2),
    .out_sel(out_sel2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sel_err(sel_err2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input string what);
    @(posedge clk);
    #1;
    $display("txn %-12s out_valid=%0b out_data=%02h out_sel=%0d sel_err=%0b in_ready=%0b",
             what, out_valid, out_data, out_sel, sel_err, in_ready);
  endtask

  task automatic expect_a(input string tag, input logic v, input logic [4:0] d,
                          input logic [1:0] s, input logic e);
    check({tag, "_valid"}, 64'(out_valid), 64'(v));
    check({tag, "_data"},  64'(out_data),  64'(d));
    check({tag, "_sel"},   64'(out_sel),   64'(s));
    check({tag, "_err"},   64'(sel_err),   64'(e));
  endtask

  logic [31:0] exp_data_q[$];
  logic [1:0]  exp_sel_q[$];
  logic        hold_prev;
  logic [31:0] hold_data;
  logic [1:0]  hold_sel;
  int          beats;

  initial begin
    // ---------------- directed: instance A ----------------
    rst_n2 = 1'b0; in_data2 = '0; sel2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b0;

    rst_n = 1'b0; in_valid = 1'b1; in_data = {5'h03, 5'h0A, 5'h15}; sel = 2'd1; out_ready = 1'b0;
    step("reset1");
    expect_a("rst1", 1'b0, 5'h00, 2'd0, 1'b0);
    check("rst1_in_ready", 64'(in_ready), 64'd1);
    step("reset2");
    expect_a("rst2", 1'b0, 5'h00, 2'd0, 1'b0);

    // lane select, full throughput
    rst_n = 1'b1; out_ready = 1'b1; sel = 2'd0;
    step("sel0");
    expect_a("lane0", 1'b1, 5'h15, 2'd0, 1'b0);
    sel = 2'd1;
    step("sel1");
    expect_a("lane1", 1'b1, 5'h0A, 2'd1, 1'b0);
    sel = 2'd2;
    step("sel2");
    expect_a("lane2", 1'b1, 5'h03, 2'd2, 1'b0);
    in_valid = 1'b0;
    step("drain");
    expect_a("drain", 1'b0, 5'h03, 2'd2, 1'b0);

    // back-pressure
    in_valid = 1'b1; sel = 2'd1;
    step("bp_accept");
    expect_a("bp_acc", 1'b1, 5'h0A, 2'd1, 1'b0);
    out_ready = 1'b0; sel = 2'd2;
    #1;
    check("bp_in_ready_comb", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step("bp_hold");
      expect_a("bp_hold", 1'b1, 5'h0A, 2'd1, 1'b0);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'd1);
    step("bp_release");
    expect_a("bp_rel", 1'b1, 5'h03, 2'd2, 1'b0);
    in_valid = 1'b0;
    step("bp_drain");
    expect_a("bp_drn", 1'b0, 5'h03, 2'd2, 1'b0);

    // out-of-range select
    in_valid = 1'b1; sel = 2'd3;
    step("oor");
    expect_a("oor", 1'b1, 5'h00, 2'd3, 1'b1);
    sel = 2'd0;
    step("oor_next");
    expect_a("oor_sticky", 1'b1, 5'h15, 2'd0, 1'b1);
    in_valid = 1'b0; rst_n = 1'b0;
    step("oor_reset");
    expect_a("oor_rst", 1'b0, 5'h00, 2'd0, 1'b0);
    rst_n = 1'b1;

    // reset while a beat is held
    in_valid = 1'b1; sel = 2'd1; out_ready = 1'b1;
    step("mid_accept");
    out_ready = 1'b0; in_valid = 1'b0;
    step("mid_hold");
    expect_a("mid_hold", 1'b1, 5'h0A, 2'd1, 1'b0);
    rst_n = 1'b0;
    step("mid_reset");
    expect_a("mid_rst", 1'b0, 5'h00, 2'd0, 1'b0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // ---------------- random scoreboard: instance B ----------------
    @(posedge clk); @(posedge clk);
    rst_n2 = 1'b1;
    hold_prev = 1'b0; hold_data = '0; hold_sel = '0; beats = 0;
    for (int c = 0; c < 420; c++) begin
      @(negedge clk);
      if (c < 400) begin
        in_valid2  = ($urandom_range(0, 3) != 0);
        sel2       = 2'($urandom_range(0, 3));
        in_data2   = {$urandom, $urandom, $urandom, $urandom};
        out_ready2 = ($urandom_range(0, 2) != 0);
      end else begin
        in_valid2  = 1'b0;
        out_ready2 = 1'b1;
      end
      #1;
      if (hold_prev) begin
        check("b_hold_data", 64'(out_data2), 64'(hold_data));
        check("b_hold_sel",  64'(out_sel2),  64'(hold_sel));
      end
      check("b_valid_vs_sb", 64'(out_valid2), 64'(exp_data_q.size() != 0));
      check("b_in_ready", 64'(in_ready2), 64'(!out_valid2 || out_ready2));
      check("b_sel_err", 64'(sel_err2), 64'd0);
      if (out_valid2 && out_ready2) begin
        if (exp_data_q.size() == 0) begin
          check("b_underflow", 64'd1, 64'd0);
        end else begin
          logic [31:0] ed;
          logic [1:0]  es;
          ed = exp_data_q.pop_front();
          es = exp_sel_q.pop_front();
          check("b_data", 64'(out_data2), 64'(ed));
          check("b_sel",  64'(out_sel2),  64'(es));
          beats++;
          $display("beat %0d data=%08h sel=%0d", beats, out_data2, out_sel2);
        end
      end
      if (in_valid2 && in_ready2) begin
        int idx;
        idx = int'(sel2);
        exp_data_q.push_back(in_data2[idx*32 +: 32]);
        exp_sel_q.push_back(sel2);
      end
      hold_prev = out_valid2 && !out_ready2;
      hold_data = out_data2;
      hold_sel  = out_sel2;
    end
    #1;
    check("b_final_empty", 64'(exp_data_q.size()), 64'd0);
    check("b_final_valid", 64'(out_valid2), 64'd0);
    check("b_beats_nonzero", 64'(beats > 50), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
